// File: rtl/seq_calc_core_if.sv
// Request/response bundle between the operand-entry FSM, the calculator core
// and display_logic. The master side issues operations and consumes results.
interface seq_calc_core_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 negative;
    logic                 div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, negative, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, negative, div_by_zero
    );
endinterface

// File: rtl/seq_calc_core.sv
// Multi-cycle unsigned calculator: single-cycle ADD/SUB, iterative shift-add
// MUL and iterative restoring DIV, each iterative op taking WIDTH cycles.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// EXEC  | operation in progress (1 cycle, or WIDTH for MUL / DIV b!=0)
// DONE  | result presented, waiting for out_ready
// 11    | unused, falls back to IDLE
module seq_calc_core #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_calc_core_if.slave    bus,
    output logic [1:0]        state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]          op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [CW-1:0]       cnt;
    // shreg: multiplier (shifted right) for MUL, dividend/quotient (shifted left) for DIV
    logic [WIDTH-1:0]    shreg;
    logic [WIDTH-1:0]    rem;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  mcand;
    logic [2*WIDTH-1:0]  result_r;
    logic                neg_r;
    logic                dz_r;

    logic [WIDTH:0]      add_sum;
    logic                a_lt_b;
    logic [WIDTH-1:0]    abs_diff;
    logic [2*WIDTH-1:0]  mul_sum;
    logic [WIDTH:0]      rem_sh;
    logic                rem_ge;
    logic [WIDTH-1:0]    rem_next;
    logic [WIDTH-1:0]    quo_next;
    logic                one_shot;
    logic                last_iter;

    assign bus.in_ready    = (state == IDLE) && !reset;
    assign bus.out_valid   = (state == DONE);
    assign bus.result      = result_r;
    assign bus.negative    = neg_r;
    assign bus.div_by_zero = dz_r;

    // Single-cycle results and the next step of the multiply / divide iterations.
    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        a_lt_b    = (a_q < b_q);
        abs_diff  = a_lt_b ? (b_q - a_q) : (a_q - b_q);
        mul_sum   = shreg[0] ? (acc + mcand) : acc;
        rem_sh    = {rem, shreg[WIDTH-1]};
        rem_ge    = (rem_sh >= {1'b0, b_q});
        // When the subtraction is taken the true difference is below b, so a
        // WIDTH-bit subtraction is exact.
        rem_next  = rem_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        quo_next  = {shreg[WIDTH-2:0], rem_ge};
        one_shot  = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                    ((op_q == OP_DIV) && (b_q == '0));
        last_iter = (cnt == LAST);
    end

    // Control FSM plus operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            shreg    <= '0;
            rem      <= '0;
            acc      <= '0;
            mcand    <= '0;
            result_r <= '0;
            neg_r    <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // reset is low here, so in_ready is high and in_valid alone accepts
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        cnt   <= '0;
                        acc   <= '0;
                        rem   <= '0;
                        mcand <= {{WIDTH{1'b0}}, bus.a};
                        shreg <= (bus.op == OP_MUL) ? bus.b : bus.a;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (one_shot) begin
                        neg_r <= 1'b0;
                        dz_r  <= 1'b0;
                        case (op_q)
                            OP_ADD:  result_r <= {{(WIDTH-1){1'b0}}, add_sum};
                            OP_SUB: begin
                                result_r <= {{WIDTH{1'b0}}, abs_diff};
                                neg_r    <= a_lt_b;
                            end
                            default: begin
                                result_r <= '0;
                                dz_r     <= 1'b1;
                            end
                        endcase
                        state <= DONE;
                    end else begin
                        if (op_q == OP_MUL) begin
                            acc   <= mul_sum;
                            mcand <= mcand << 1;
                            shreg <= shreg >> 1;
                        end else begin
                            rem   <= rem_next;
                            shreg <= quo_next;
                        end
                        if (last_iter) begin
                            result_r <= (op_q == OP_MUL) ? mul_sum : {rem_next, quo_next};
                            neg_r    <= 1'b0;
                            dz_r     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_core.sv
// Bench for seq_calc_core at WIDTH=8: directed vector table, random ops
// against an arithmetic reference, and hand-written handshake/reset sequences.
module tb_seq_calc_core;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        n;
        logic        dz;
        int          lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state;
    int         total = 0;
    int         bad = 0;

    seq_calc_core_if #(.WIDTH(8)) bus ();

    seq_calc_core #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's definition.
    function automatic vec_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int ia = int'(a);
        int ib = int'(b);
        v.op = op; v.a = a; v.b = b; v.n = 1'b0; v.dz = 1'b0; v.lat = 1; v.r = '0;
        case (op)
            ADD: v.r = 16'(ia + ib);
            SUB: begin
                v.r = 16'((ia < ib) ? ib - ia : ia - ib);
                v.n = (ia < ib);
            end
            MUL: begin
                v.r   = 16'(ia * ib);
                v.lat = 8;
            end
            default: begin
                if (ib == 0) begin
                    v.dz = 1'b1;
                end else begin
                    v.r   = 16'((ia % ib) * 256 + ia / ib);
                    v.lat = 8;
                end
            end
        endcase
        return v;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] r, output logic n, output logic dz,
                         output int lat, output logic busy_ready);
        @(negedge clk);
        bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.op = ~o; bus.a = ~x; bus.b = ~y;
        lat = 0;
        busy_ready = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            busy_ready = busy_ready | bus.in_ready;
            @(negedge clk);
            lat++;
        end
        r = bus.result; n = bus.negative; dz = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    vec_t        vecs[12];
    vec_t        m;
    logic [15:0] r;
    logic        n, dz, br;
    int          lat;

    initial begin
        vecs[0]  = '{ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1};
        vecs[1]  = '{SUB, 8'd5,   8'd9,   16'h0004, 1'b1, 1'b0, 1};
        vecs[2]  = '{SUB, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b0, 1};
        vecs[3]  = '{MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 8};
        vecs[4]  = '{DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 8};
        vecs[5]  = '{DIV, 8'd13,  8'd0,   16'h0000, 1'b0, 1'b1, 1};
        vecs[6]  = '{ADD, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1};
        vecs[7]  = '{SUB, 8'd255, 8'd0,   16'h00FF, 1'b0, 1'b0, 1};
        vecs[8]  = '{DIV, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 8};
        vecs[9]  = '{DIV, 8'd5,   8'd9,   16'h0500, 1'b0, 1'b0, 8};
        vecs[10] = '{MUL, 8'd0,   8'd200, 16'h0000, 1'b0, 1'b0, 8};
        vecs[11] = '{MUL, 8'd15,  8'd15,  16'h00E1, 1'b0, 1'b0, 8};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = ADD; bus.a = '0; bus.b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'(2'b00));
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_flags", 32'({bus.negative, bus.div_by_zero}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'h1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, r, n, dz, lat, br);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_neg", i), 32'(n), 32'(vecs[i].n));
            chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy_ready", i), 32'(br), 32'h0);
        end

        // Random operations against the reference
        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [7:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = 8'($urandom_range(0, 255));
            y = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            m = model(o, x, y);
            issue(o, x, y, r, n, dz, lat, br);
            chk($sformatf("rnd%0d_result op=%0d a=%0d b=%0d", i, o, x, y), 32'(r), 32'(m.r));
            chk($sformatf("rnd%0d_flags", i), 32'({n, dz}), 32'({m.n, m.dz}));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(m.lat));
        end

        // Back-pressure with a request held valid across DONE
        @(negedge clk);
        bus.op = ADD; bus.a = 8'd3; bus.b = 8'd4; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_exec_state", 32'(state), 32'(2'b01));
        bus.op = ADD; bus.a = 8'd1; bus.b = 8'd1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_result", i), 32'(bus.result), 32'd7);
            chk($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'h0);
        end
        chk("bp_done_state", 32'(state), 32'(2'b10));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_back_idle", 32'(state), 32'(2'b00));
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'h1);
        chk("bp_result_kept", 32'(bus.result), 32'd7);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("held_req_accepted", 32'(state), 32'(2'b01));
        @(negedge clk);
        @(negedge clk);
        chk("held_req_valid", 32'(bus.out_valid), 32'h1);
        chk("held_req_result", 32'(bus.result), 32'd2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("after_hs_result_kept", 32'(bus.result), 32'd2);
        chk("after_hs_out_valid", 32'(bus.out_valid), 32'h0);

        // Reset in the middle of a multiply
        issue(SUB, 8'd5, 8'd9, r, n, dz, lat, br);
        chk("pre_rst_neg", 32'(n), 32'h1);
        @(negedge clk);
        bus.op = MUL; bus.a = 8'd15; bus.b = 8'd15; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'(2'b00));
        chk("midrst_result", 32'(bus.result), 32'h0);
        chk("midrst_flags", 32'({bus.negative, bus.div_by_zero}), 32'h0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        issue(MUL, 8'd15, 8'd15, r, n, dz, lat, br);
        chk("post_rst_mul_result", 32'(r), 32'd225);
        chk("post_rst_mul_latency", 32'(lat), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_calc_core.md
Name: seq_calc_core

Overview:
Parametrised successor to the 4-bit calculator datapath and ALU. It takes WIDTH-bit operands through a valid/ready handshake and executes ADD, SUB, MUL or DIV. MUL is an iterative shift-add and DIV an iterative restoring divider, each taking WIDTH cycles. Results are returned on a valid/ready output handshake with flags. It sits between the operand-entry FSM and display_logic, which consumes the result.

Parameters:
WIDTH, 8, operand width in bits (WIDTH >= 2); result is 2*WIDTH bits.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands and op are valid
in_ready  output  1  core can accept a request
op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer accepts the result
result  output  2*WIDTH  result, format depends on op
negative  output  1  SUB with a < b
div_by_zero  output  1  DIV with b == 0
state  output  2  current FSM state, for debug/HEX display

Behaviour:
Clock and reset:
- reset is asynchronous, active-high; clock is clk.
- While reset is high: state = IDLE, result = 0, negative = 0, div_by_zero = 0, out_valid = 0, in_ready = 0, iteration counter = 0.

States (encoding):
- IDLE = 00, EXEC = 01, DONE = 10; 11 is unused and recovers to IDLE.

Handshakes:
- in_ready = 1 only in IDLE with reset low.
- A request is accepted on an edge where in_valid && in_ready.
- On acceptance, a, b and op are captured into internal registers, and the core moves to EXEC with counter = 0.
- Changes on the input ports after acceptance are ignored.
- out_valid = 1 exactly when state = DONE.
- On an edge with out_ready high in DONE, the core moves to IDLE.
- in_ready is 0 in DONE, so no new request is accepted on the same edge as the output handshake.
- While out_valid && !out_ready, result and flags hold stable.
- After the output handshake, result and flags keep their values until the next operation completes.
- negative and div_by_zero are cleared whenever a new result is written.

Latency (acceptance edge to the first edge with out_valid = 1):
- ADD, SUB, and DIV with b == 0: 1 cycle. EXEC lasts one cycle.
- MUL, and DIV with b != 0: WIDTH cycles. EXEC lasts WIDTH cycles; the counter runs 0..WIDTH-1 and the core goes to DONE when counter == WIDTH-1.

Arithmetic (all unsigned):
- ADD: result = zero-extended (a + b), WIDTH+1 significant bits; the carry is kept.
- SUB: result = |a - b| zero-extended; negative = 1 iff a < b; a == b gives result 0, negative 0.
- MUL: result = a * b, full 2*WIDTH bits. One partial-product add/shift per EXEC cycle.
- DIV, b != 0: result[WIDTH-1:0] = a / b, result[2*WIDTH-1:WIDTH] = a % b. One restoring step per EXEC cycle, MSB first.
- DIV, b == 0: result = 0, div_by_zero = 1; no iterations are run.

Boundary conditions:
- Reset mid-EXEC or mid-DONE aborts the operation: all outputs return to their reset values and nothing is kept from the aborted operation.
- A request held valid across DONE is accepted only on the first edge after returning to IDLE.
- in_valid with in_ready low has no effect.
- MUL of all-ones operands must not overflow the 2*WIDTH result.

Test Plan:
All scenarios use WIDTH=8.
1. ADD a=200, b=100 -> result 0x012C (300), negative 0; out_valid 1 cycle after acceptance.
2. SUB a=5, b=9 -> result 4, negative 1. Then SUB a=9, b=9 -> result 0, negative 0.
3. MUL a=255, b=255 -> result 0xFE01 (65025); out_valid exactly 8 cycles after acceptance; in_ready 0 throughout.
4. DIV a=200, b=7 -> result 0x041C (quotient 28, remainder 4) after 8 cycles. DIV a=13, b=0 -> result 0, div_by_zero 1, latency 1.
5. Back-pressure: ADD 3+4 with out_ready held low 5 cycles -> result 7 stable, out_valid high, in_ready 0. out_ready high -> IDLE next edge, in_ready 1.
6. Reset pulse at cycle 4 of MUL 15*15 -> all outputs 0, state IDLE. A following MUL 15*15 -> 225 after 8 cycles.
